operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- Decode/operand-fetch stage between instruction fetch and execute in the RV32I core.
- Drives the register file read addresses from the incoming instruction and captures the returned operands.
- Adds a same-cycle writeback bypass, because register file writes land only at the clock edge.
- Interlocks RAW/WAW hazards with a per-register busy scoreboard, then registers {pc, insn, rs1_val, rs2_val} into the ID/EX output register behind a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSN, 32'h0000_0013, out_insn value when the slot is empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low: state resets on a posedge where rst==0.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_insn  in  32  instruction word.
- rf_ra1  out  5  register file read address 1 = in_insn[19:15], combinational.
- rf_ra2  out  5  register file read address 2 = in_insn[24:20], combinational.
- rf_rd1  in  XLEN  register file read data 1.
- rf_rd2  in  XLEN  register file read data 2.
- wb_we  in  1  writeback enable (same net as the register file we).
- wb_wa  in  5  writeback address.
- wb_wd  in  XLEN  writeback data.
- flush  in  1  execute-stage redirect; kills the output-register entry.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  execute consumes the entry.
- out_pc  out  XLEN  registered PC.
- out_insn  out  32  registered instruction.
- out_rs1_val  out  XLEN  registered rs1 operand.
- out_rs2_val  out  XLEN  registered rs2 operand.
- stall_cnt  out  32  count of cycles with in_valid=1 and hazard=1; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst==0 at posedge): out_valid=0, out_pc=0, out_insn=NOP_INSN, out_rs1_val=0, out_rs2_val=0, busy[31:0]=0, stall_cnt=0. While rst==0, in_ready=0.
- Decode, opcode = insn[6:0]:
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, or SYSTEM with funct3!=0; only when rd!=0.
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP, or SYSTEM with funct3 in {1,2,3}.
  - uses_rs2: BRANCH, STORE, OP.
- Operand select, per source: x0 gives 0. Otherwise, if wb_we && wb_wa==rs, use wb_wd (bypass). Otherwise use rf_rdN.
- A busy bit is visible as eff_busy[r] = busy[r] && !(wb_we && wb_wa==r).
- hazard = in_valid && ((uses_rs1 && eff_busy[rs1]) || (uses_rs2 && eff_busy[rs2]) || (writes_rd && eff_busy[rd])). The rd term is the WAW interlock.
- in_ready = rst && !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready.
- Output register, priority order:
  1. flush: out_valid<=0, out_insn<=NOP_INSN; no accept.
  2. accept: load all out_* and set out_valid<=1.
  3. out_ready && out_valid: out_valid<=0.
  4. otherwise: hold.
- Latency is 1 cycle from accept to out_valid. Back-to-back accepts run at full throughput when out_ready=1.
- While out_valid && !out_ready, all out_* hold stable.
- Scoreboard, each cycle:
  - A wb_we with wb_wa!=0 clears busy[wb_wa].
  - An accept with writes_rd sets busy[rd]; set beats a same-cycle clear.
  - A flush with out_valid and the out entry writing rd clears busy[out rd]. This beats the other events for that register; the block never accepts in a flush cycle.
- Only the output-register entry is flushed. Older instructions downstream always reach writeback, so their busy bits clear normally.
- x0 is never marked busy.
- stall_cnt increments every cycle with rst==1 and hazard==1; it holds at all-ones.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> out_valid=0, out_insn=32'h13, stall_cnt=0, in_ready=0; release -> in_ready=1.
- Bypass: rf_rd1=5, wb_we=1, wb_wa=3, wb_wd=0xABCD, in_insn=add x4,x3,x0 -> out_rs1_val=0xABCD, out_rs2_val=0 next cycle.
- RAW interlock: accept addi x5,x0,7, then add x6,x5,x5 -> in_ready=0 and stall_cnt rises until wb_we=1, wb_wa=5, wb_wd=7. In that same cycle accept occurs with out_rs1_val=out_rs2_val=7.
- Backpressure: out_ready=0 for 3 cycles with a valid entry -> out_* stable and in_ready=0; out_ready=1 -> next instruction accepted, throughput 1/cycle.
- Flush: out entry is lw x7,0(x1) and flush=1 -> out_valid=0, busy[7] cleared, and a following add x8,x7,x0 is accepted with no stall.
- WAW plus x0: accept addi x9,x0,1, then addi x9,x0,2 -> second stalls until wb_wa=9. addi x0,x0,1 followed by add x1,x0,x0 -> no stall.

Source files
------------

// File: rtl/operand_stage.sv
// RV32I decode/operand-fetch stage: register-file read with writeback bypass,
// busy-scoreboard RAW/WAW interlock, and a valid/ready ID/EX output register.
module operand_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_insn,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_insn,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [31:0]     stall_cnt
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Returns {writes_rd, uses_rs1, uses_rs2}; writes_rd already excludes rd==x0.
    function automatic logic [2:0] f_decode(input logic [31:0] insn);
        logic [2:0] d;
        logic [2:0] f3;
        d  = 3'b000;
        f3 = insn[14:12];
        case (insn[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: d = 3'b100;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: d = 3'b110;
            OPC_OP:                        d = 3'b111;
            OPC_BRANCH, OPC_STORE:         d = 3'b011;
            OPC_SYSTEM: begin
                d[2] = (f3 != 3'd0);
                d[1] = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
            end
            default:                       d = 3'b000;
        endcase
        if (insn[11:7] == 5'd0) d[2] = 1'b0;
        return d;
    endfunction

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_dec;
    logic [2:0]      w_out_dec;
    logic [31:0]     w_wb_mask;
    logic [31:0]     w_eff_busy;
    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [31:0]     w_busy_nxt;
    logic [31:0]     r_busy;

    assign w_rs1     = in_insn[19:15];
    assign w_rs2     = in_insn[24:20];
    assign w_rd      = in_insn[11:7];
    assign rf_ra1    = w_rs1;
    assign rf_ra2    = w_rs2;
    assign w_dec     = f_decode(in_insn);
    assign w_out_dec = f_decode(out_insn);

    // A register being written back this cycle is no longer busy for the reader.
    assign w_wb_mask  = wb_we ? (32'd1 << wb_wa) : 32'd0;
    assign w_eff_busy = r_busy & ~w_wb_mask;

    assign w_hazard = in_valid && ((w_dec[1] && w_eff_busy[w_rs1]) ||
                                   (w_dec[0] && w_eff_busy[w_rs2]) ||
                                   (w_dec[2] && w_eff_busy[w_rd]));
    assign in_ready = rst && !flush && !w_hazard && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    assign w_op1 = (w_rs1 == 5'd0) ? '0 : ((wb_we && wb_wa == w_rs1) ? wb_wd : rf_rd1);
    assign w_op2 = (w_rs2 == 5'd0) ? '0 : ((wb_we && wb_wa == w_rs2) ? wb_wd : rf_rd2);

    // Scoreboard: writeback clears, accept sets, flush of the out entry clears last.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_we && wb_wa != 5'd0) w_busy_nxt[wb_wa] = 1'b0;
        if (w_accept && w_dec[2]) w_busy_nxt[w_rd] = 1'b1;
        if (flush && out_valid && w_out_dec[2]) w_busy_nxt[out_insn[11:7]] = 1'b0;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_insn    <= NOP_INSN;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            r_busy      <= '0;
            stall_cnt   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_hazard && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (flush) begin
                out_valid <= 1'b0;
                out_insn  <= NOP_INSN;
            end else if (w_accept) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_insn    <= in_insn;
                out_rs1_val <= w_op1;
                out_rs2_val <= w_op2;
            end else if (out_ready && out_valid) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus random traffic, checked
// cycle by cycle against a behavioural model of the stage.
module tb_operand_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_we, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_insn, rf_rd1, rf_rd2, wb_wd;
    logic [31:0] out_pc, out_insn, out_rs1_val, out_rs2_val, stall_cnt;
    logic [4:0]  rf_ra1, rf_ra2, wb_wa;

    int checks = 0;
    int failures = 0;

    bit          m_busy[32];
    logic        m_ov;
    logic [31:0] m_pc, m_insn, m_r1, m_r2, m_stall;
    logic        last_acc;

    operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_wa(wb_wa),
        .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wr(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return i[11:7] != 5'd0;
            7'h73: return i[14:12] != 3'd0 && i[11:7] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_u1(input logic [31:0] i);
        case (i[6:0])
            7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
            7'h73: return i[14:12] >= 3'd1 && i[14:12] <= 3'd3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_u2(input logic [31:0] i);
        return i[6:0] == 7'h63 || i[6:0] == 7'h23 || i[6:0] == 7'h33;
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction

    function automatic logic [31:0] rnd_insn();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67; 4: op = 7'h63;
            5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13; 8: op = 7'h33; default: op = 7'h73;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ov = 1'b0; m_pc = '0; m_insn = NOP; m_r1 = '0; m_r2 = '0; m_stall = '0;
    endtask

    // One clock: combinational checks mid-cycle, model update at the edge, registered checks after.
    task automatic cyc();
        logic [4:0]  rs1, rs2, rd;
        logic        hz, rdy, acc;
        logic [31:0] v1, v2;
        bit          busy_rs1, busy_rs2, busy_rd;
        #2;
        rs1 = in_insn[19:15]; rs2 = in_insn[24:20]; rd = in_insn[11:7];
        busy_rs1 = m_busy[rs1] && !(wb_we && wb_wa == rs1);
        busy_rs2 = m_busy[rs2] && !(wb_we && wb_wa == rs2);
        busy_rd  = m_busy[rd]  && !(wb_we && wb_wa == rd);
        hz  = in_valid && ((m_u1(in_insn) && busy_rs1) || (m_u2(in_insn) && busy_rs2) ||
                           (m_wr(in_insn) && busy_rd));
        rdy = rst && !flush && !hz && (!m_ov || out_ready);
        acc = in_valid && rdy;
        v1  = (rs1 == 0) ? 32'd0 : (wb_we && wb_wa == rs1) ? wb_wd : rf_rd1;
        v2  = (rs2 == 0) ? 32'd0 : (wb_we && wb_wa == rs2) ? wb_wd : rf_rd2;
        chk("rf_ra1", 32'(rf_ra1), 32'(rs1));
        chk("rf_ra2", 32'(rf_ra2), 32'(rs2));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        last_acc = acc;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (wb_we && wb_wa != 0) m_busy[wb_wa] = 1'b0;
            if (acc && m_wr(in_insn)) m_busy[rd] = 1'b1;
            if (flush && m_ov && m_wr(m_insn)) m_busy[m_insn[11:7]] = 1'b0;
            if (flush) begin
                m_ov = 1'b0; m_insn = NOP;
            end else if (acc) begin
                m_ov = 1'b1; m_pc = in_pc; m_insn = in_insn; m_r1 = v1; m_r2 = v2;
            end else if (out_ready && m_ov) begin
                m_ov = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_pc", out_pc, m_pc);
        chk("out_insn", out_insn, m_insn);
        chk("out_rs1_val", out_rs1_val, m_r1);
        chk("out_rs2_val", out_rs2_val, m_r2);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic idle();
        in_valid = 0; wb_we = 0; flush = 0; out_ready = 1;
    endtask

    task automatic wb(input int r);
        in_valid = 0; wb_we = 1; wb_wa = 5'(r); wb_wd = 32'($urandom); cyc(); wb_we = 0;
    endtask

    initial begin
        logic [31:0] s0;
        model_reset();
        rst = 0; in_valid = 1; in_pc = 32'h40; in_insn = addi(1, 0, 1);
        rf_rd1 = 0; rf_rd2 = 0; wb_we = 0; wb_wa = 0; wb_wd = 0; flush = 0; out_ready = 1;
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_insn", out_insn, 32'h13);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1; idle(); #2;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        cyc();

        // bypass from writeback
        in_valid = 1; in_pc = 32'h80; in_insn = add(4, 3, 0); rf_rd1 = 5; rf_rd2 = 32'h99;
        wb_we = 1; wb_wa = 3; wb_wd = 32'hABCD;
        cyc();
        chk("byp_rs1", out_rs1_val, 32'hABCD);
        chk("byp_rs2", out_rs2_val, 32'd0);
        wb(4);

        // RAW interlock
        in_valid = 1; in_pc = 32'h100; in_insn = addi(5, 0, 7); cyc();
        s0 = stall_cnt;
        in_pc = 32'h104; in_insn = add(6, 5, 5); rf_rd1 = 1; rf_rd2 = 2;
        repeat (3) cyc();
        chk("raw_stall_cnt", stall_cnt, s0 + 32'd3);
        chk("raw_held", out_pc, 32'h100);
        wb_we = 1; wb_wa = 5; wb_wd = 7; #2;
        chk("raw_release_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("raw_rs1", out_rs1_val, 32'd7);
        chk("raw_rs2", out_rs2_val, 32'd7);
        wb(6);

        // backpressure then full throughput
        in_valid = 1; in_pc = 32'h200; in_insn = addi(10, 0, 1); out_ready = 1; cyc();
        out_ready = 0; in_pc = 32'h204; in_insn = addi(11, 0, 2);
        repeat (3) cyc();
        chk("bp_pc", out_pc, 32'h200);
        chk("bp_insn", out_insn, addi(10, 0, 1));
        out_ready = 1; cyc();
        chk("bp_acc1", out_pc, 32'h204);
        in_pc = 32'h208; in_insn = addi(12, 0, 3); cyc();
        chk("bp_acc2", out_pc, 32'h208);
        wb(10); wb(11); wb(12);

        // flush clears the out entry and its busy bit
        in_valid = 1; in_pc = 32'h300; in_insn = lw(7, 1); cyc();
        flush = 1; in_pc = 32'h304; in_insn = add(8, 7, 0); cyc();
        chk("flush_ov", 32'(out_valid), 32'd0);
        flush = 0; s0 = stall_cnt; cyc();
        chk("flush_acc", out_insn, add(8, 7, 0));
        chk("flush_nostall", stall_cnt, s0);
        wb(8);

        // WAW interlock and x0 never busy
        in_valid = 1; in_pc = 32'h400; in_insn = addi(9, 0, 1); cyc();
        in_insn = addi(9, 0, 2); in_pc = 32'h404; repeat (2) cyc();
        chk("waw_held", out_pc, 32'h400);
        wb_we = 1; wb_wa = 9; wb_wd = 1; in_valid = 1; cyc(); wb_we = 0;
        chk("waw_acc", out_pc, 32'h404);
        wb(9);
        in_valid = 1; in_pc = 32'h500; in_insn = addi(0, 0, 1); cyc();
        s0 = stall_cnt; in_pc = 32'h504; in_insn = add(1, 0, 0); cyc();
        chk("x0_acc", out_pc, 32'h504);
        chk("x0_nostall", stall_cnt, s0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) >= 2);
            in_valid  = ($urandom_range(0, 9) < 8);
            in_pc     = 32'($urandom);
            in_insn   = rnd_insn();
            rf_rd1    = 32'($urandom);
            rf_rd2    = 32'($urandom);
            wb_we     = ($urandom_range(0, 1) == 1);
            wb_wa     = 5'($urandom_range(0, 3));
            wb_wd     = 32'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
